// File: rtl/hack_pkg.sv
// Shared Hack instruction encoding: bit positions, ALU control bundle and dest/jump fields.
package hack_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned INSTR_TYPE_BIT = 15;
    localparam int unsigned A_BIT          = 12;
    localparam int unsigned COMP_MSB       = 11;
    localparam int unsigned COMP_LSB       = 6;
    localparam int unsigned DEST_A         = 5;
    localparam int unsigned DEST_D         = 4;
    localparam int unsigned DEST_M         = 3;
    localparam int unsigned JMP_LT         = 2;
    localparam int unsigned JMP_EQ         = 1;
    localparam int unsigned JMP_GT         = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef struct packed {
        logic a;
        logic d;
        logic m;
    } dest_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jump_t;

endpackage

// File: rtl/hack_alu.sv
// 16-bit Hack ALU: operand zero/negate stages, add-or-and, output negate, zero/negative flags.
module hack_alu
    import hack_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  alu_ctrl_t   ctrl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] fx;

    always_comb begin
        x_z = ctrl.zx ? 16'h0000 : x;
        x_n = ctrl.nx ? ~x_z : x_z;
        y_z = ctrl.zy ? 16'h0000 : y;
        y_n = ctrl.ny ? ~y_z : y_z;
        fx  = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out = ctrl.no ? ~fx : fx;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU core: instruction decode, A/D/PC registers, jump resolution and data-memory write port.
module hack_cpu_core
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           instr,
    input  logic                  instr_valid,
    input  logic [15:0]           in_m,
    output logic [15:0]           out_m,
    output logic                  write_m,
    output logic [ADDR_WIDTH-1:0] address_m,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           dbg_d
);

    logic [15:0]           a_reg;
    logic [15:0]           d_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;

    logic        is_c;
    alu_ctrl_t   ctrl;
    dest_t       dest;
    jump_t       jump;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        take;
    logic        unused_bits;

    // Decode is purely combinational; instr[14:13] carry no meaning.
    always_comb begin
        is_c        = instr[INSTR_TYPE_BIT];
        ctrl        = alu_ctrl_t'(instr[COMP_MSB:COMP_LSB]);
        dest        = dest_t'(instr[DEST_A:DEST_M]);
        jump        = jump_t'(instr[JMP_LT:JMP_GT]);
        alu_y       = instr[A_BIT] ? in_m : a_reg;
        take        = (jump.lt & alu_ng) | (jump.eq & alu_zr) | (jump.gt & ~alu_ng & ~alu_zr);
        unused_bits = ^instr[14:13];
    end

    hack_alu u_alu (
        .x    (d_reg),
        .y    (alu_y),
        .ctrl (ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Jump target and write address both use the pre-edge A value.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            pc_reg <= ADDR_WIDTH'(RESET_PC);
        end else if (instr_valid) begin
            if (!is_c) begin
                a_reg  <= instr;
                pc_reg <= pc_reg + ADDR_WIDTH'(1);
            end else begin
                if (dest.a) a_reg <= alu_out;
                if (dest.d) d_reg <= alu_out;
                pc_reg <= take ? a_reg[ADDR_WIDTH-1:0] : (pc_reg + ADDR_WIDTH'(1));
            end
        end
    end

    assign out_m     = alu_out;
    assign write_m   = instr_valid & is_c & dest.m & ~rst;
    assign address_m = a_reg[ADDR_WIDTH-1:0];
    assign pc        = pc_reg;
    assign dbg_d     = d_reg;

endmodule
